// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder controller: one decimal digit per clock, LSD first,
// with a registered decimal carry, sticky non-BCD error flag and done pulse.
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  carry_in,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] a_r;
  logic [4*DIGITS-1:0] b_r;
  logic                carry;

  logic [3:0] a_d;
  logic [3:0] b_d;
  logic [4:0] s;
  logic [4:0] s_corr;
  logic [3:0] digit;
  logic       c_next;
  logic       bad_digit;
  logic       last;

  // Digit select as a compare-mux so idx width never leaks into slice arithmetic
  always_comb begin
    a_d = '0;
    b_d = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        a_d = a_r[4*i +: 4];
        b_d = b_r[4*i +: 4];
      end
    end
  end

  always_comb begin
    s         = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, carry};
    s_corr    = s + 5'd6;
    c_next    = (s > 5'd9);
    digit     = c_next ? s_corr[3:0] : s[3:0];
    bad_digit = (a_d > 4'd9) || (b_d > 4'd9);
    last      = (idx == IW'(DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_r       <= a;
            b_r       <= b;
            carry     <= carry_in;
            sum       <= '0;
            carry_out <= 1'b0;
            err       <= 1'b0;
            idx       <= '0;
            state     <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) sum[4*i +: 4] <= digit;
          end
          carry <= c_next;
          if (bad_digit) err <= 1'b1;
          if (last) begin
            carry_out <= c_next;
            state     <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl with DIGITS=4.
module tb_bcd_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic [15:0] sum;
  logic        carry_out;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .carry_in(carry_in), .sum(sum), .carry_out(carry_out),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic cin);
    exp_t r;
    int c;
    int d;
    int xd;
    int yd;
    r.sum = '0;
    r.err = 1'b0;
    c = int'(cin);
    for (int i = 0; i < 4; i++) begin
      xd = int'(x[4*i +: 4]);
      yd = int'(y[4*i +: 4]);
      if (xd > 9 || yd > 9) r.err = 1'b1;
      d = xd + yd + c;
      if (d >= 10) begin
        d = (d - 10) % 16;
        c = 1;
      end else begin
        c = 0;
      end
      r.sum[4*i +: 4] = 4'(d);
    end
    r.cout = (c == 1);
    return r;
  endfunction

  // Pulse start for one accepting edge, push the expectation, then scramble operands.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic cin, input bit push);
    @(negedge clk);
    a = x; b = y; carry_in = cin; start = 1'b1;
    if (push) q.push_back(model(x, y, cin));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom);
  endtask

  task automatic wait_done(output int busy_cycles, output bit ok);
    busy_cycles = 0;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sum !== 16'h0) begin errors++; $display("FAIL reset_sum got %h want 0000", sum); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", carry_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    rst_n = 1'b1;
  endtask

  task automatic check_result(input string name);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++; $display("FAIL %s_queue got done with empty scoreboard", name);
      return;
    end
    e = q.pop_front();
    if (sum !== e.sum) begin errors++; $display("FAIL %s_sum got %h want %h", name, sum, e.sum); end
    checks++;
    if (carry_out !== e.cout) begin errors++; $display("FAIL %s_cout got %b want %b", name, carry_out, e.cout); end
    checks++;
    if (err !== e.err) begin errors++; $display("FAIL %s_err got %b want %b", name, err, e.err); end
  endtask

  task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y, input logic cin);
    int bc;
    bit ok;
    start_op(x, y, cin, 1'b1);
    wait_done(bc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout got no done want done", name); void'(q.pop_front()); return; end
    check_result(name);
    checks++;
    if (bc != 4) begin errors++; $display("FAIL %s_busy_cycles got %0d want 4", name, bc); end
  endtask

  task automatic test_basic;
    run_op("basic", 16'h1234, 16'h5678, 1'b0);
    checks++; if (sum !== 16'h6912) begin errors++; $display("FAIL basic_const got %h want 6912", sum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
    checks++; if (sum !== 16'h6912) begin errors++; $display("FAIL basic_hold got %h want 6912", sum); end
  endtask

  task automatic test_ripple;
    run_op("ripple", 16'h9999, 16'h0001, 1'b0);
    run_op("cin_only", 16'h0000, 16'h0000, 1'b1);
    run_op("cin_ripple", 16'h4999, 16'h5000, 1'b1);
    checks++; if ({carry_out, sum} !== 17'h10000) begin errors++; $display("FAIL cin_ripple_const got %h want 10000", {carry_out, sum}); end
  endtask

  task automatic test_back_to_back;
    int bc;
    bit ok;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; carry_in = 1'b0; start = 1'b1;
    q.push_back(model(16'h1111, 16'h2222, 1'b0));
    @(posedge clk);
    #1;
    a = 16'h0458; b = 16'h0767; carry_in = 1'b1;
    q.push_back(model(16'h0458, 16'h0767, 1'b1));
    wait_done(bc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_first_timeout got no done want done"); start = 1'b0; q.delete(); return; end
    check_result("b2b_first");
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width got %b want 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise got %b want 1", busy); end
    wait_done(bc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_second_timeout got no done want done"); q.delete(); return; end
    check_result("b2b_second");
    checks++; if (bc != 3) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 3", bc); end
  endtask

  task automatic test_err;
    run_op("nonbcd", 16'h00A3, 16'h0001, 1'b0);
    checks++; if (sum[3:0] !== 4'h4 || err !== 1'b1) begin errors++; $display("FAIL nonbcd_digit0 got %h/%b want 4/1", sum[3:0], err); end
    run_op("err_clear", 16'h0012, 16'h0034, 1'b0);
  endtask

  task automatic test_abort;
    start_op(16'h0045, 16'h0055, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    checks++; if (sum !== 16'h0) begin errors++; $display("FAIL abort_sum got %h want 0000", sum); end
    checks++; if ({carry_out, err} !== 2'b00) begin errors++; $display("FAIL abort_cout_err got %b want 00", {carry_out, err}); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_abort", 16'h0045, 16'h0055, 1'b0);
    checks++; if ({carry_out, sum} !== 17'h00100) begin errors++; $display("FAIL after_abort_const got %h want 00100", {carry_out, sum}); end
  endtask

  task automatic test_random;
    logic [15:0] x;
    logic [15:0] y;
    for (int i = 0; i < 8; i++) begin
      for (int d = 0; d < 4; d++) begin
        x[4*d +: 4] = 4'($urandom_range(9, 0));
        y[4*d +: 4] = 4'($urandom_range(9, 0));
      end
      run_op("random", x, y, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_back_to_back();
    test_err();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
